// File: rtl/gcd_pkg.sv
// Shared types for the GCD requester: data width, requester FSM states and
// the operand pair carried through the request FIFO.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_RESP  = 3'd4
    } gcd_req_state_t;

    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Small synchronous FIFO of operand pairs. Pointers carry one extra wrap bit
// so full and empty are told apart without an occupancy counter. The head
// entry is visible on pop_data whenever the FIFO is not empty.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  gcd_pair_t push_data,
    input  logic      pop,
    output gcd_pair_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    gcd_pair_t   mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_en;
    logic        pop_en;

    // Guard both ports so a misbehaving caller cannot corrupt the pointers.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because empty masks stale data.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/gcd_requester.sv
// Requester front end for one 16-bit GCD unit: buffers operand pairs, issues
// them one at a time, collects the result and returns it with the operands.
// Optional build macro GCD_REQ_TIMEOUT_EN adds a WAIT timeout and the
// acknowledge of late (stale) results; without it WAIT waits indefinitely.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [GCD_W-1:0] req_a,
    input  logic [GCD_W-1:0] req_b,
    output logic             operands_val,
    output logic [GCD_W-1:0] op_a,
    output logic [GCD_W-1:0] op_b,
    input  logic             ready,
    input  logic             gcd_valid,
    input  logic [GCD_W-1:0] gcd_out,
    output logic             ack_rcvd,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [GCD_W-1:0] resp_gcd,
    output logic [GCD_W-1:0] resp_a,
    output logic [GCD_W-1:0] resp_b,
    output logic             resp_timeout
);

    gcd_req_state_t   state_reg;
    gcd_req_state_t   state_next;

    logic [GCD_W-1:0] op_a_reg;
    logic [GCD_W-1:0] op_b_reg;
    logic [GCD_W-1:0] resp_gcd_reg;
    logic [GCD_W-1:0] resp_a_reg;
    logic [GCD_W-1:0] resp_b_reg;

    gcd_pair_t        fifo_in;
    gcd_pair_t        fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    logic             load_ops;
    logic             capture_gcd;
    logic             take_timeout;
    logic             tmo_hit;
    logic             stale_ack;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    assign fifo_in.a = req_a;
    assign fifo_in.b = req_b;
    assign fifo_push = req_val && !fifo_full;
    assign req_rdy   = !fifo_full;

    gcd_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Timeout and stale-result acknowledge
    // ------------------------------------------------------------------
`ifdef GCD_REQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] tmo_cnt_reg;
    logic          resp_timeout_reg;
    logic          stale_ack_reg;
    logic          stale_window;

    // WAIT lasts exactly TIMEOUT cycles when no result arrives.
    assign tmo_hit = (tmo_cnt_reg == CW'(TIMEOUT - 1));

    // A result is stale when no request is outstanding: in IDLE, or while a
    // timeout response is still being offered.
    assign stale_window = (state_reg == ST_IDLE) ||
                          ((state_reg == ST_RESP) && resp_timeout_reg);

    // Count WAIT cycles; restart while ISSUE is about to enter WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_ISSUE) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
        end
    end

    // One-cycle ack for a stale result; the self-mask stops a second pulse
    // while the GCD unit is still dropping gcd_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stale_ack_reg <= 1'b0;
        end else begin
            stale_ack_reg <= gcd_valid && stale_window && !stale_ack_reg;
        end
    end

    // Timeout flag travels with the response data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_timeout_reg <= 1'b0;
        end else if (capture_gcd) begin
            resp_timeout_reg <= 1'b0;
        end else if (take_timeout) begin
            resp_timeout_reg <= 1'b1;
        end
    end

    assign stale_ack    = stale_ack_reg;
    assign resp_timeout = resp_timeout_reg;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign tmo_hit        = 1'b0;
    assign stale_ack      = 1'b0;
    assign resp_timeout   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and datapath strobes; a real result wins over a
    // timeout that expires in the same cycle.
    always_comb begin
        state_next   = state_reg;
        fifo_pop     = 1'b0;
        load_ops     = 1'b0;
        capture_gcd  = 1'b0;
        take_timeout = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && ready) begin
                    fifo_pop   = 1'b1;
                    load_ops   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_valid) begin
                    capture_gcd = 1'b1;
                    state_next  = ST_ACK;
                end else if (tmo_hit) begin
                    take_timeout = 1'b1;
                    state_next   = ST_RESP;
                end
            end
            ST_ACK: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand registers change only when a new pair is taken, so the GCD
    // unit sees stable inputs while it reloads them in its idle state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_reg <= '0;
            op_b_reg <= '0;
        end else if (load_ops) begin
            op_a_reg <= fifo_head.a;
            op_b_reg <= fifo_head.b;
        end
    end

    // Response payload: result (or zero on timeout) plus the issued operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_gcd_reg <= '0;
            resp_a_reg   <= '0;
            resp_b_reg   <= '0;
        end else if (capture_gcd || take_timeout) begin
            resp_gcd_reg <= capture_gcd ? gcd_out : '0;
            resp_a_reg   <= op_a_reg;
            resp_b_reg   <= op_b_reg;
        end
    end

    assign operands_val = (state_reg == ST_ISSUE);
    assign ack_rcvd     = (state_reg == ST_ACK) || stale_ack;
    assign resp_val     = (state_reg == ST_RESP);
    assign op_a         = op_a_reg;
    assign op_b         = op_b_reg;
    assign resp_gcd     = resp_gcd_reg;
    assign resp_a       = resp_a_reg;
    assign resp_b       = resp_b_reg;

endmodule
